// File: rtl/disp_pkg.sv
// Shared types and constants for the pixel fetch stage: FSM state encoding,
// the largest supported memory latency and the sync polarity selectors.
package disp_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } fetch_state_t;

    localparam int   MEM_LAT_MAX  = 4;
    localparam logic SYNC_POL_POS = 1'b1;
    localparam logic SYNC_POL_NEG = 1'b0;

endpackage

// File: rtl/pixel_fetch_stage_delay_line.sv
// delay_line: WIDTH-bit shift register, DEPTH stages deep, with a synchronous
// active-low clear that empties every stage at once.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/pixel_fetch_stage.sv
// pixel_fetch_stage: issues framebuffer reads for active pixels and re-times sync/blank
// to the memory latency. Optional stripe generator: define PIXEL_FETCH_TEST_PATTERN_EN.
module pixel_fetch_stage
    import disp_pkg::*;
#(
    parameter int   ADDR_W   = 19,
    parameter int   PIX_W    = 8,
    parameter int   MEM_LAT  = 2,
    parameter logic SYNC_POL = SYNC_POL_POS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_blank_i,
    input  logic              h_sync_i,
    input  logic              v_blank_i,
    input  logic              v_sync_i,
    input  logic [ADDR_W-1:0] addr_i,
`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    input  logic              pattern_i,
`endif
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [PIX_W-1:0]  mem_data_i,
    output logic [PIX_W-1:0]  rgb_o,
    output logic              h_sync_o,
    output logic              v_sync_o,
    output logic              de_o,
    output logic              locked_o,
    output logic [7:0]        frame_cnt_o
);

    localparam int LAT = (MEM_LAT < 1) ? 1 :
                         ((MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT);

    fetch_state_t     r_state;
    fetch_state_t     w_nextState;
    logic             r_vBlankQ;
    logic [7:0]       r_frameCnt;
    logic [PIX_W-1:0] r_rgb;
    logic             r_de;
    logic             r_hSync;
    logic             r_vSync;

    logic             w_deRaw;
    logic             w_vbRise;
    logic [2:0]       w_dlyOut;
    logic             w_dlyHs;
    logic             w_dlyVs;
    logic             w_dlyDe;
    logic             w_showPix;
    logic [PIX_W-1:0] w_pixel;

    assign w_deRaw    = ~h_blank_i & ~v_blank_i;
    assign w_vbRise   = v_blank_i & ~r_vBlankQ;
    assign locked_o   = (r_state == S_RUN);
    assign mem_addr_o = addr_i;

    delay_line #(
        .WIDTH (3),
        .DEPTH (LAT)
    ) u_syncDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({h_sync_i, v_sync_i, w_deRaw}),
        .o_data (w_dlyOut)
    );

    assign {w_dlyHs, w_dlyVs, w_dlyDe} = w_dlyOut;
    assign w_showPix = w_dlyDe & locked_o;

`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    logic [PIX_W-1:0] w_dlyStripe;

    // Only the stripe bits of the address are ever displayed, so only they are delayed.
    delay_line #(
        .WIDTH (PIX_W),
        .DEPTH (LAT)
    ) u_addrDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (addr_i[PIX_W+3:4]),
        .o_data (w_dlyStripe)
    );

    assign mem_rd_en_o = w_deRaw & locked_o & ~pattern_i;
    assign w_pixel     = pattern_i ? w_dlyStripe : mem_data_i;
`else
    assign mem_rd_en_o = w_deRaw & locked_o;
    assign w_pixel     = mem_data_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_WAIT;
            r_vBlankQ  <= 1'b0;
            r_frameCnt <= 8'd0;
        end else begin
            r_state   <= w_nextState;
            r_vBlankQ <= v_blank_i;
            if ((r_state == S_RUN) && w_vbRise) begin
                r_frameCnt <= r_frameCnt + 8'd1;
            end
        end
    end

    // Lock only on a blank->active transition so the first shown frame is complete.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_WAIT:  if (v_blank_i) w_nextState = S_ARM;
            S_ARM:   if (r_vBlankQ && !v_blank_i) w_nextState = S_RUN;
            S_RUN:   w_nextState = S_RUN;
            default: w_nextState = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rgb   <= '0;
            r_de    <= 1'b0;
            r_hSync <= ~SYNC_POL;
            r_vSync <= ~SYNC_POL;
        end else begin
            r_rgb   <= w_showPix ? w_pixel : '0;
            r_de    <= w_showPix;
            r_hSync <= w_dlyHs ~^ SYNC_POL;
            r_vSync <= w_dlyVs ~^ SYNC_POL;
        end
    end

    assign rgb_o       = r_rgb;
    assign de_o        = r_de;
    assign h_sync_o    = r_hSync;
    assign v_sync_o    = r_vSync;
    assign frame_cnt_o = r_frameCnt;

endmodule
